// File: rtl/nn_backprop_updater.sv
// nn_backprop_updater: backward-pass weight updater for a 4-3-1 ReLU network.
// Ports: clk/rst_n, start/busy/done control, in1..in4 (2-bit int inputs),
//   h1..h3/out_o1/target (signed fixed point), w_flat (15 current weights),
//   wr_valid/wr_ready/wr_idx/wr_data (weight write port, valid/ready).
// Latency: start at cycle 0 -> writes from cycle 5, done at cycle 20 with
//   wr_ready held high; every cycle of wr_ready low adds one cycle.
module nn_backprop_updater #(
  parameter int W        = 16,
  parameter int FRAC     = 8,
  parameter int LR_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic [1:0]       in1,
  input  logic [1:0]       in2,
  input  logic [1:0]       in3,
  input  logic [1:0]       in4,
  input  logic [W-1:0]     h1,
  input  logic [W-1:0]     h2,
  input  logic [W-1:0]     h3,
  input  logic [W-1:0]     out_o1,
  input  logic [W-1:0]     target,
  input  logic [15*W-1:0]  w_flat,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [3:0]       wr_idx,
  output logic [W-1:0]     wr_data
);

  // PW: full-precision product / hidden delta width. SW: update-sum width,
  // wide enough for delta * 3 plus the old weight without overflow.
  localparam int PW = 2*W + 1;
  localparam int SW = 2*W + 4;
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_HDELTA, S_EMIT_OUT, S_EMIT_IN, S_DONE
  } state_t;

  state_t                state;
  logic [1:0]            in_q [4];
  logic signed [W-1:0]   h_q  [3];
  logic signed [W-1:0]   w_q  [15];
  logic signed [W-1:0]   out_q;
  logic signed [W-1:0]   tgt_q;
  logic signed [W:0]     e_o;
  logic signed [PW-1:0]  d_q  [3];
  logic [1:0]            hj;

  // Hidden delta for the neuron selected by hj (ReLU derivative gate).
  logic signed [PW-1:0]  hd_prod;
  logic signed [PW-1:0]  hd_val;

  always_comb begin
    hd_prod = PW'(e_o) * PW'(w_q[4'd12 + {2'b00, hj}]);
    hd_val  = '0;
    if (!h_q[hj][W-1] && (h_q[hj] != '0))
      hd_val = hd_prod >>> FRAC;
  end

  // Next index to present and its updated weight. Computed one step ahead so
  // wr_idx/wr_data come straight from registers.
  logic [3:0]            nxt_idx;
  logic                  nxt_out;
  logic [1:0]            nxt_i;
  logic [1:0]            nxt_j;
  logic signed [PW-1:0]  o_prod;
  logic signed [SW-1:0]  i_prod;
  logic signed [SW-1:0]  upd;
  logic signed [SW-1:0]  sum;
  logic [W-1:0]          nxt_data;

  always_comb begin
    nxt_idx = 4'd12;
    if (state != S_HDELTA)
      nxt_idx = (wr_idx == 4'd14) ? 4'd0 : wr_idx + 4'd1;
    nxt_out = (nxt_idx >= 4'd12);
    nxt_i   = 2'(nxt_idx / 4'd3);
    nxt_j   = nxt_out ? 2'(nxt_idx - 4'd12) : 2'(nxt_idx % 4'd3);
    o_prod  = PW'(e_o) * PW'(h_q[nxt_j]);
    i_prod  = SW'(d_q[nxt_j]) * SW'($signed({1'b0, in_q[nxt_i]}));
    if (nxt_out)
      upd = SW'((o_prod >>> FRAC) >>> LR_SHIFT);
    else
      upd = i_prod >>> LR_SHIFT;
    sum = SW'(w_q[nxt_idx]) + upd;
    if (sum > SAT_MAX)
      nxt_data = SAT_MAX[W-1:0];
    else if (sum < SAT_MIN)
      nxt_data = SAT_MIN[W-1:0];
    else
      nxt_data = sum[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_valid <= 1'b0;
      wr_idx   <= '0;
      wr_data  <= '0;
      out_q    <= '0;
      tgt_q    <= '0;
      e_o      <= '0;
      hj       <= '0;
      for (int k = 0; k < 4; k++)  in_q[k] <= '0;
      for (int k = 0; k < 3; k++)  h_q[k]  <= '0;
      for (int k = 0; k < 3; k++)  d_q[k]  <= '0;
      for (int k = 0; k < 15; k++) w_q[k]  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            in_q[0] <= in1;
            in_q[1] <= in2;
            in_q[2] <= in3;
            in_q[3] <= in4;
            h_q[0]  <= h1;
            h_q[1]  <= h2;
            h_q[2]  <= h3;
            out_q   <= out_o1;
            tgt_q   <= target;
            for (int k = 0; k < 15; k++) w_q[k] <= w_flat[k*W +: W];
            busy    <= 1'b1;
            state   <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          e_o   <= (W+1)'(tgt_q) - (W+1)'(out_q);
          hj    <= '0;
          state <= S_HDELTA;
        end
        S_HDELTA: begin
          d_q[hj] <= hd_val;
          if (hj == 2'd2) begin
            // First write (idx 12) depends only on e_o and h1.
            wr_valid <= 1'b1;
            wr_idx   <= nxt_idx;
            wr_data  <= nxt_data;
            state    <= S_EMIT_OUT;
          end else begin
            hj <= hj + 2'd1;
          end
        end
        S_EMIT_OUT, S_EMIT_IN: begin
          if (wr_ready) begin
            if (wr_idx == 4'd11) begin
              wr_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= S_DONE;
            end else begin
              wr_idx  <= nxt_idx;
              wr_data <= nxt_data;
              if (wr_idx == 4'd14)
                state <= S_EMIT_IN;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_backprop_updater.sv
// Directed bench for nn_backprop_updater: hand-computed write values,
// write order, done timing, stall stability, start-while-busy, async reset.
module tb_nn_backprop_updater;

  localparam int W = 16;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [1:0]           in1, in2, in3, in4;
  logic [W-1:0]         h1, h2, h3, out_o1, target;
  logic [15*W-1:0]      w_flat;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [3:0]           wr_idx;
  logic signed [W-1:0]  wr_data;

  nn_backprop_updater #(.W(W), .FRAC(8), .LR_SHIFT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .h1(h1), .h2(h2), .h3(h3), .out_o1(out_o1), .target(target),
    .w_flat(w_flat), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_idx(wr_idx), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int nw;
  int done_cyc;
  logic [3:0]          got_idx [15];
  logic signed [W-1:0] got_dat [15];

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp_v);
    vecs++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic set_w(input int idx, input int val);
    w_flat[idx*W +: W] = W'(val);
  endtask

  task automatic set_defaults();
    in1 = 2'd1; in2 = 2'd1; in3 = 2'd1; in4 = 2'd1;
    h1 = 16'sd128; h2 = 16'sd128; h3 = 16'sd128;
    out_o1 = 16'sd100; target = 16'sd100;
    for (int k = 0; k < 15; k++) set_w(k, 64);
  endtask

  // Start a sample and collect writes. stall: cycles to hold wr_ready low
  // once the first write is pending (start is pulsed during the stall).
  // abort_idx >= 0: assert reset while that index is pending.
  task automatic run(input int stall, input int abort_idx);
    int st_left;
    logic [3:0] s_idx;
    logic signed [W-1:0] s_dat;
    bit seen;
    nw = 0; done_cyc = -1; st_left = stall; seen = 0;
    s_idx = '0; s_dat = '0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 1) chk("busy_cycle1", busy, 1);
      if (abort_idx >= 0 && wr_valid && wr_idx == abort_idx[3:0]) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        return;
      end
      if (wr_valid && st_left > 0) begin
        wr_ready = 1'b0;
        if (!seen) begin
          s_idx = wr_idx; s_dat = wr_data; seen = 1;
          chk("stall_first_idx", wr_idx, 12);
        end else begin
          chk("stall_idx_stable", wr_idx, s_idx);
          chk("stall_dat_stable", wr_data, s_dat);
          chk("stall_valid_held", wr_valid, 1);
        end
        if (st_left == 3) start = 1'b1;
        st_left--;
      end else begin
        wr_ready = 1'b1;
      end
      if (wr_valid && wr_ready) begin
        if (nw < 15) begin
          got_idx[nw] = wr_idx;
          got_dat[nw] = wr_data;
        end
        nw++;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  // Expected write order: 12,13,14,0..11.
  task automatic chk_seq(input string tag, input int exp_done);
    chk({tag, "_nwrites"}, nw, 15);
    chk({tag, "_done_cycle"}, done_cyc, exp_done);
    chk({tag, "_busy_at_done"}, busy, 0);
    for (int k = 0; k < 15; k++)
      chk($sformatf("%s_order%0d", tag, k), got_idx[k], (k < 3) ? 12 + k : k - 3);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; wr_ready = 1'b1; w_flat = '0;
    set_defaults();
    #12;
    chk("reset_wr_valid", wr_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_wr_idx", wr_idx, 0);
    chk("reset_wr_data", wr_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: zero error -> every weight rewritten unchanged.
    set_defaults();
    run(0, -1);
    chk_seq("zero_err", 20);
    for (int k = 0; k < 15; k++)
      chk($sformatf("zero_err_data%0d", k), got_dat[k], 64);

    // 2: e_o = 256.
    set_defaults();
    target = 16'sd256; out_o1 = 16'sd0; in1 = 2'd2;
    set_w(12, 128); set_w(0, 0);
    run(0, -1);
    chk_seq("e256", 20);
    chk("e256_idx12", got_dat[0], 160);
    chk("e256_idx13", got_dat[1], 96);
    chk("e256_idx0", got_dat[3], 64);
    chk("e256_idx1", got_dat[4], 96);
    chk("e256_idx4", got_dat[7], 80);

    // 3: same with h2 = 0 -> neuron 2 paths unchanged.
    h2 = 16'sd0;
    run(0, -1);
    chk("h2zero_idx12", got_dat[0], 160);
    chk("h2zero_idx13", got_dat[1], 64);
    chk("h2zero_idx1", got_dat[4], 64);
    chk("h2zero_idx4", got_dat[7], 64);
    chk("h2zero_idx7", got_dat[10], 64);
    chk("h2zero_idx10", got_dat[13], 64);
    chk("h2zero_idx0", got_dat[3], 64);

    // 4: saturation, both directions.
    set_defaults();
    set_w(12, 32767); h1 = 16'sd32767;
    target = 16'sd32767; out_o1 = 16'h8000;
    run(0, -1);
    chk("sat_pos_idx12", got_dat[0], 32767);
    set_w(12, -32768); h1 = 16'sd32767;
    target = 16'h8000; out_o1 = 16'sd32767;
    run(0, -1);
    chk("sat_neg_idx12", got_dat[0], -32768);

    // 5: 5-cycle stall on idx12, start pulsed while busy.
    set_defaults();
    run(5, -1);
    chk_seq("stall", 25);

    // 6: reset while idx5 pending, then a clean full sample.
    set_defaults();
    run(0, 5);
    repeat (2) @(posedge clk);
    #1;
    chk("in_reset_wr_valid", wr_valid, 0);
    rst_n = 1'b1;
    run(0, -1);
    chk_seq("post_rst", 20);
    chk("post_rst_idx12", got_dat[0], 64);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/nn_backprop_updater.md
Name: nn_backprop_updater

Overview:
- Sequential backward-pass engine for the 4-input / 3-hidden / 1-output network.
- Takes one training sample: inputs, hidden activations, network output and target. Computes the output and hidden error terms, then streams 15 updated weights to the weight store over a valid/ready write port.
- It is the writer of the weights that the forward network reads. All values are signed fixed point; no real types.

Parameters:
- W, 16, weight/activation/target width (signed two's complement)
- FRAC, 8, fractional bits of every W-bit value (1.0 = 256 at default)
- LR_SHIFT, 2, learning rate = 2^-LR_SHIFT (arithmetic right shift)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; accepted only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last weight write is accepted
- in1, in2, in3, in4  in  2 each  unsigned integer network inputs (0..3)
- h1, h2, h3  in  W each  hidden activations, signed Q(W-FRAC).FRAC
- out_o1  in  W  network output, signed fixed point
- target  in  W  desired output, signed fixed point
- w_flat  in  15*W  current weights; w_flat[k*W +: W] = weight index k
- wr_valid  out  1  write request
- wr_ready  in  1  weight store accepts the write when wr_valid && wr_ready
- wr_idx  out  4  weight index 0..14
- wr_data  out  W  updated weight

Behaviour:
- Weight map:
  - idx = (i-1)*3 + (j-1) for input i (1..4) → hidden j (1..3); this gives w1..w12.
  - idx 12, 13, 14 = hidden j=1, 2, 3 → output (w13..w15).
  - Biases are not updated.
- Reset: state=IDLE; busy, done, wr_valid = 0; wr_idx = 0; wr_data = 0; all captured registers = 0. Reset mid-operation abandons the sequence immediately; no further writes are issued.
- FSM states: IDLE → CAPTURE → HDELTA (3 cycles, j=1,2,3) → EMIT_OUT (idx 12,13,14) → EMIT_IN (idx 0..11 ascending) → DONE → IDLE.
- IDLE:
  - start=1 registers all data inputs, including w_flat, and moves to CAPTURE.
  - Data inputs are ignored after that edge.
  - start while busy or in DONE is ignored; it is not queued.
- CAPTURE:
  - e_o = target - out_o1, computed at W+1 bits with no overflow.
- HDELTA j:
  - d_j = ((e_o * w_out_j) >>> FRAC) when h_j > 0, else 0. This is a ReLU derivative.
  - w_out_j is the captured (old) value of weight 12+j-1.
  - d_j is held at full precision, 2W+1 bits.
- EMIT_OUT idx 12+j-1:
  - upd = ((e_o * h_j) >>> FRAC) >>> LR_SHIFT
  - wr_data = sat_W(w_old + upd)
- EMIT_IN idx for (i, j):
  - upd = (d_j * in_i) >>> LR_SHIFT. in_i is an integer, so there is no FRAC shift.
  - wr_data = sat_W(w_old + upd)
- sat_W clamps to [-2^(W-1), 2^(W-1)-1]. Shifts are arithmetic, truncating toward -inf.
- Every index is emitted exactly once per sample, even if its value is unchanged.
- Write handshake:
  - wr_valid is asserted in EMIT states.
  - wr_idx and wr_data are stable while wr_valid && !wr_ready.
  - The index advances only on acceptance.
  - wr_valid is deasserted in DONE and IDLE.
- Latency: with wr_ready held at 1, start at cycle 0 gives:
  - CAPTURE at cycle 1
  - HDELTA at cycles 2-4
  - writes at cycles 5-19
  - done=1 at cycle 20
  - Each cycle that wr_ready is low adds one cycle.
- busy is high from cycle 1 through the last accepted write and low when done pulses.

Test Plan:
- Defaults; target=out_o1=100, all weights 64, h=128, inputs=1; start → 15 writes in order 12,13,14,0..11, each wr_data=64; done at cycle 20.
- target=256, out_o1=0, h1=128, w13(idx12)=128, w1(idx0)=0, in1=2 → idx12 data=160 (128+32); d_1=128; idx0 data=64.
- Same as previous but h2=0 → idx 1,4,7,10 data equal their old weights; idx13 data = old + 0.
- w13=32767, h1=32767, target=32767, out_o1=-32768 → idx12 data=32767 (saturated); mirror negative case → -32768.
- wr_ready held low 5 cycles while idx12 is pending → wr_valid, wr_idx and wr_data are stable throughout; done at cycle 25; start pulsed while busy has no effect.
- rst_n low while idx 5 is pending → wr_valid, busy, done = 0 asynchronously; a new start then yields the full 15-write sequence beginning at idx12.
